// File: rtl/point_memory_bank.sv
// Point store for the LiDAR clustering datapath: x/y/z coordinates plus a label per point,
// two registered read ports, and a sequential label-clear sweep.
module point_memory_bank #(
   parameter int N = 16,
   parameter int AW = 4,
   parameter int CW = 8,
   parameter int LW = 4,
   parameter logic [LW-1:0] LABEL_INIT = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   output logic          busy,
   input  logic          pt_we,
   input  logic [AW-1:0] pt_waddr,
   input  logic [CW-1:0] pt_x,
   input  logic [CW-1:0] pt_y,
   input  logic [CW-1:0] pt_z,
   input  logic          lbl_we,
   input  logic [AW-1:0] lbl_waddr,
   input  logic [LW-1:0] lbl_wdata,
   input  logic          rd_en,
   input  logic [AW-1:0] raddr_i,
   input  logic [AW-1:0] raddr_j,
   output logic          rd_valid,
   output logic [CW-1:0] xi,
   output logic [CW-1:0] yi,
   output logic [CW-1:0] zi,
   output logic [CW-1:0] xj,
   output logic [CW-1:0] yj,
   output logic [CW-1:0] zj,
   output logic [LW-1:0] li,
   output logic [LW-1:0] lj
);

   // One extra bit so N == 2**AW is representable.
   localparam logic [AW:0] NUM  = (AW+1)'(N);
   localparam logic [AW:0] LAST = (AW+1)'(N - 1);

   typedef enum logic {
      ST_CLEAR,
      ST_IDLE
   } state_t;

   typedef struct packed {
      logic [CW-1:0] x;
      logic [CW-1:0] y;
      logic [CW-1:0] z;
      logic [LW-1:0] l;
   } rec_t;

   state_t        state;
   state_t        state_nxt;
   logic [AW-1:0] cnt;
   logic [AW-1:0] cnt_nxt;

   logic [CW-1:0] mem_x [N];
   logic [CW-1:0] mem_y [N];
   logic [CW-1:0] mem_z [N];
   logic [LW-1:0] mem_l [N];

   logic pt_ok;
   logic lbl_ok;
   logic rd_ok;
   rec_t rec_i;
   rec_t rec_j;

   function automatic logic in_range(input logic [AW-1:0] a);
      return {1'b0, a} < NUM;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      busy      = 1'b0;
      unique case (state)
         ST_CLEAR: begin
            busy    = 1'b1;
            cnt_nxt = cnt + AW'(1);
            if ({1'b0, cnt} == LAST) begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
            end
         end
         ST_IDLE: begin
            if (clr) begin
               state_nxt = ST_CLEAR;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = ST_CLEAR;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign pt_ok  = pt_we & in_range(pt_waddr);
   assign lbl_ok = lbl_we & in_range(lbl_waddr) & ~busy;
   assign rd_ok  = rd_en & ~busy;

   always_ff @(posedge clk) begin
      if (pt_ok) begin
         mem_x[pt_waddr] <= pt_x;
         mem_y[pt_waddr] <= pt_y;
         mem_z[pt_waddr] <= pt_z;
      end
   end

   always_ff @(posedge clk) begin
      if (busy) begin
         mem_l[cnt] <= LABEL_INIT;
      end else if (lbl_ok) begin
         mem_l[lbl_waddr] <= lbl_wdata;
      end
   end

   // Write-first: a same-cycle write to the read address wins over the array.
   always_comb begin
      rec_i = '0;
      if (in_range(raddr_i)) begin
         rec_i.x = mem_x[raddr_i];
         rec_i.y = mem_y[raddr_i];
         rec_i.z = mem_z[raddr_i];
         rec_i.l = mem_l[raddr_i];
         if (pt_ok && pt_waddr == raddr_i) begin
            rec_i.x = pt_x;
            rec_i.y = pt_y;
            rec_i.z = pt_z;
         end
         if (lbl_ok && lbl_waddr == raddr_i) begin
            rec_i.l = lbl_wdata;
         end
      end
   end

   always_comb begin
      rec_j = '0;
      if (in_range(raddr_j)) begin
         rec_j.x = mem_x[raddr_j];
         rec_j.y = mem_y[raddr_j];
         rec_j.z = mem_z[raddr_j];
         rec_j.l = mem_l[raddr_j];
         if (pt_ok && pt_waddr == raddr_j) begin
            rec_j.x = pt_x;
            rec_j.y = pt_y;
            rec_j.z = pt_z;
         end
         if (lbl_ok && lbl_waddr == raddr_j) begin
            rec_j.l = lbl_wdata;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_valid <= 1'b0;
         xi       <= '0;
         yi       <= '0;
         zi       <= '0;
         li       <= '0;
         xj       <= '0;
         yj       <= '0;
         zj       <= '0;
         lj       <= '0;
      end else begin
         rd_valid <= rd_ok;
         if (rd_ok) begin
            xi <= rec_i.x;
            yi <= rec_i.y;
            zi <= rec_i.z;
            li <= rec_i.l;
            xj <= rec_j.x;
            yj <= rec_j.y;
            zj <= rec_j.z;
            lj <= rec_j.l;
         end
      end
   end

endmodule

// File: tb/tb_point_memory_bank.sv
// Directed bench for point_memory_bank: a default N=16 instance and an N=12 instance
// (LABEL_INIT=5) share one stimulus stream.
module tb_point_memory_bank;

   logic       clk;
   logic       rst;
   logic       clr;
   logic       pt_we;
   logic [3:0] pt_waddr;
   logic [7:0] pt_x;
   logic [7:0] pt_y;
   logic [7:0] pt_z;
   logic       lbl_we;
   logic [3:0] lbl_waddr;
   logic [3:0] lbl_wdata;
   logic       rd_en;
   logic [3:0] raddr_i;
   logic [3:0] raddr_j;

   logic       busy, rd_valid;
   logic [7:0] xi, yi, zi, xj, yj, zj;
   logic [3:0] li, lj;

   logic       busy12, rd_valid12;
   logic [7:0] xi12, yi12, zi12, xj12, yj12, zj12;
   logic [3:0] li12, lj12;

   int tests = 0;
   int fails = 0;
   int b16;
   int b12;

   point_memory_bank dut (
      .clk(clk), .rst(rst), .clr(clr), .busy(busy),
      .pt_we(pt_we), .pt_waddr(pt_waddr),
      .pt_x(pt_x), .pt_y(pt_y), .pt_z(pt_z),
      .lbl_we(lbl_we), .lbl_waddr(lbl_waddr), .lbl_wdata(lbl_wdata),
      .rd_en(rd_en), .raddr_i(raddr_i), .raddr_j(raddr_j),
      .rd_valid(rd_valid),
      .xi(xi), .yi(yi), .zi(zi), .xj(xj), .yj(yj), .zj(zj),
      .li(li), .lj(lj)
   );

   point_memory_bank #(.N(12), .LABEL_INIT(4'h5)) dut12 (
      .clk(clk), .rst(rst), .clr(clr), .busy(busy12),
      .pt_we(pt_we), .pt_waddr(pt_waddr),
      .pt_x(pt_x), .pt_y(pt_y), .pt_z(pt_z),
      .lbl_we(lbl_we), .lbl_waddr(lbl_waddr), .lbl_wdata(lbl_wdata),
      .rd_en(rd_en), .raddr_i(raddr_i), .raddr_j(raddr_j),
      .rd_valid(rd_valid12),
      .xi(xi12), .yi(yi12), .zi(zi12), .xj(xj12), .yj(yj12), .zj(zj12),
      .li(li12), .lj(lj12)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      clr    = 1'b0;
      pt_we  = 1'b0;
      lbl_we = 1'b0;
      rd_en  = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic pt_wr(input logic [3:0] a, input logic [7:0] x, y, z);
      pt_we    = 1'b1;
      pt_waddr = a;
      pt_x     = x;
      pt_y     = y;
      pt_z     = z;
   endtask

   task automatic lbl_wr(input logic [3:0] a, input logic [3:0] d);
      lbl_we    = 1'b1;
      lbl_waddr = a;
      lbl_wdata = d;
   endtask

   task automatic rd(input logic [3:0] a, input logic [3:0] b);
      rd_en   = 1'b1;
      raddr_i = a;
      raddr_j = b;
   endtask

   task automatic count_sweep();
      b16 = 0;
      b12 = 0;
      for (int k = 0; k < 20; k++) begin
         if (busy) b16++;
         if (busy12) b12++;
         step();
      end
   endtask

   initial begin
      rst = 1'b1;
      idle();
      pt_waddr  = '0;
      pt_x      = '0;
      pt_y      = '0;
      pt_z      = '0;
      lbl_waddr = '0;
      lbl_wdata = '0;
      raddr_i   = '0;
      raddr_j   = '0;

      // Reset state
      step();
      step();
      chk("rst_busy", busy, 1);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_xi", xi, 0);
      chk("rst_lj", lj, 0);

      // Sweep length after reset
      rst = 1'b0;
      count_sweep();
      chk("sweep16_len", b16, 16);
      chk("sweep12_len", b12, 12);

      // All labels cleared
      for (int a = 0; a < 16; a++) begin
         rd(4'(a), 4'(15 - a));
         step();
         chk("init_valid", rd_valid, 1);
         chk("init_li", li, 0);
         chk("init_lj", lj, 0);
      end
      idle();

      // Point write then dual read
      pt_wr(4'd3, 8'd10, 8'd20, 8'd30);
      step();
      pt_wr(4'd7, 8'd1, 8'd2, 8'd3);
      step();
      idle();
      rd(4'd3, 4'd7);
      step();
      chk("rd_valid", rd_valid, 1);
      chk("xi3", xi, 10);
      chk("yi3", yi, 20);
      chk("zi3", zi, 30);
      chk("xj7", xj, 1);
      chk("yj7", yj, 2);
      chk("zj7", zj, 3);
      idle();
      step();
      chk("rd_idle_valid", rd_valid, 0);
      chk("rd_idle_hold", xi, 10);

      // Coordinate bypass, same address on both ports
      pt_wr(4'd9, 8'd4, 8'd5, 8'd6);
      rd(4'd9, 4'd9);
      step();
      idle();
      chk("byp_xi", xi, 4);
      chk("byp_zi", zi, 6);
      chk("byp_xj", xj, 4);
      chk("byp_yj", yj, 5);

      // Label bypass
      lbl_wr(4'd5, 4'd9);
      rd(4'd5, 4'd4);
      step();
      idle();
      chk("lbyp_li", li, 9);
      chk("lbyp_lj", lj, 0);
      rd(4'd5, 4'd5);
      step();
      idle();
      chk("lbl5_li", li, 9);

      // Point and label to the same address in one cycle
      pt_wr(4'd5, 8'd7, 8'd8, 8'd9);
      lbl_wr(4'd5, 4'd3);
      step();
      idle();
      rd(4'd5, 4'd3);
      step();
      idle();
      chk("both_li", li, 3);
      chk("both_xi", xi, 7);
      chk("both_xj", xj, 10);

      // Clear sweep on request
      lbl_wr(4'd2, 4'd4);
      step();
      idle();
      rd(4'd2, 4'd5);
      step();
      idle();
      chk("pre_clr_li", li, 4);
      clr = 1'b1;
      step();
      idle();
      b16 = 0;
      for (int k = 0; k < 20; k++) begin
         if (busy) b16++;
         idle();
         case (k)
            0: begin
               lbl_wr(4'd2, 4'd6);
               rd(4'd2, 4'd2);
            end
            1: pt_wr(4'd11, 8'd50, 8'd60, 8'd70);
            3: clr = 1'b1;
            14: lbl_wr(4'd2, 4'd6);
            15: rd(4'd2, 4'd2);
            default: ;
         endcase
         step();
         if (k == 0 || k == 15) chk("busy_rd_valid", rd_valid, 0);
      end
      idle();
      chk("clr_len", b16, 16);
      rd(4'd2, 4'd5);
      step();
      chk("clr_li2", li, 0);
      chk("clr_lj5", lj, 0);
      rd(4'd11, 4'd3);
      step();
      idle();
      chk("busy_pt_x", xi, 50);
      chk("busy_pt_z", zi, 70);
      chk("keep_pt_x", xj, 10);

      // Reset in the middle of a sweep
      clr = 1'b1;
      step();
      idle();
      repeat (8) step();
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", busy, 1);
      chk("mid_rst_valid", rd_valid, 0);
      chk("mid_rst_xi", xi, 0);
      step();
      rst = 1'b0;
      count_sweep();
      chk("restart_len16", b16, 16);
      chk("restart_len12", b12, 12);

      // Out-of-range addresses on the N=12 instance
      pt_wr(4'd13, 8'd99, 8'd99, 8'd99);
      lbl_wr(4'd13, 4'd7);
      rd(4'd11, 4'd13);
      step();
      idle();
      chk("oor_valid", rd_valid12, 1);
      chk("oor_xj", xj12, 0);
      chk("oor_yj", yj12, 0);
      chk("oor_zj", zj12, 0);
      chk("oor_lj", lj12, 0);
      chk("n12_xi11", xi12, 50);
      chk("n12_li11", li12, 5);
      chk("n16_xj13", xj, 99);
      chk("n16_lj13", lj, 7);
      lbl_wr(4'd11, 4'd2);
      pt_wr(4'd12, 8'd88, 8'd88, 8'd88);
      step();
      idle();
      rd(4'd11, 4'd12);
      step();
      idle();
      chk("n12_last_li", li12, 2);
      chk("n12_at_n_xj", xj12, 0);
      chk("n12_at_n_lj", lj12, 0);
      rd(4'd3, 4'd13);
      step();
      idle();
      chk("n12_xi3", xi12, 10);
      chk("n12_oor_zj", zj12, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
